// File: rtl/uart_tx_if.sv
// Handshake bundle between the data source and the UART transmitter.
// The producer drives the word and request, and watches TX_OUT/Busy.
interface uart_tx_if #(
   parameter int DATA_LENGTH = 8
);
   logic [DATA_LENGTH-1:0] P_DATA;
   logic                   DATA_VALID;
   logic                   PAR_EN;
   logic                   PAR_TYP;
   logic                   TX_OUT;
   logic                   Busy;

   modport master (
      output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      input  TX_OUT, Busy
   );

   modport slave (
      input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
      output TX_OUT, Busy
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter clocked at the baud rate: one clock period per bit.
// Frame = start(0), data LSB first, optional parity, stop(1).
// TX_OUT and Busy come straight from flops.
module uart_tx #(
   parameter int DATA_LENGTH = 8
) (
   input  logic     CLK,
   input  logic     RST,
   uart_tx_if.slave bus
);
   localparam int CW = $clog2(DATA_LENGTH + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 r_state;
   logic [DATA_LENGTH-1:0] r_data;     // latched word, shifted right as bits go out
   logic [CW-1:0]          r_cnt;      // data bits already driven onto the line
   logic                   r_par_en;
   logic                   r_par_bit;  // parity computed once, from the word at acceptance
   logic                   r_tx;
   logic                   r_busy;

   assign bus.TX_OUT = r_tx;
   assign bus.Busy   = r_busy;

   // Frame sequencer; each state's output is the bit currently on the line.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= IDLE;
         r_data    <= '0;
         r_cnt     <= '0;
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               if (bus.DATA_VALID) begin
                  // PAR_TYP only matters through the parity bit, so it is
                  // folded in here rather than kept as its own register.
                  r_data    <= bus.P_DATA;
                  r_par_en  <= bus.PAR_EN;
                  r_par_bit <= (^bus.P_DATA) ^ bus.PAR_TYP;
                  r_cnt     <= '0;
                  r_tx      <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= START;
               end
            end
            START: begin
               r_tx    <= r_data[0];
               r_data  <= r_data >> 1;
               r_cnt   <= CW'(1);
               r_state <= DATA;
            end
            DATA: begin
               if (r_cnt == CW'(DATA_LENGTH)) begin
                  if (r_par_en) begin
                     r_tx    <= r_par_bit;
                     r_state <= PARITY;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end
               end else begin
                  r_tx   <= r_data[0];
                  r_data <= r_data >> 1;
                  r_cnt  <= r_cnt + CW'(1);
               end
            end
            PARITY: begin
               r_tx    <= 1'b1;
               r_state <= STOP;
            end
            STOP: begin
               // Busy drops here, so the next request lands one idle bit later.
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of directed frames, random frames
// against a bit-list frame model, plus hand-written reset sequences.
module tb_uart_tx;
   localparam int DL = 8;

   logic CLK = 1'b0;
   logic RST;
   int   checks = 0;
   int   errors = 0;

   uart_tx_if #(.DATA_LENGTH(DL)) bus ();

   uart_tx #(.DATA_LENGTH(DL)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [DL-1:0] d;
      logic          pen;
      logic          ptyp;
      logic          par;   // expected parity bit
      int            len;   // expected Busy cycles
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Frame model: the line shows these bits one per cycle after acceptance.
   // Called at a negedge; returns at a negedge with the line idle.
   task automatic run_frame(input string nm, input logic [DL-1:0] d,
                            input logic pen, input logic ptyp,
                            input logic exp_par, input int exp_len,
                            input bit disturb);
      logic bits[$];
      int   busy_cnt;
      bits.push_back(1'b0);
      for (int i = 0; i < DL; i++) bits.push_back(d[i]);
      if (pen) bits.push_back(exp_par);
      bits.push_back(1'b1);
      bus.P_DATA     = d;
      bus.PAR_EN     = pen;
      bus.PAR_TYP    = ptyp;
      bus.DATA_VALID = 1'b1;
      @(negedge CLK);
      bus.DATA_VALID = 1'b0;
      busy_cnt = 0;
      for (int k = 0; k < bits.size(); k++) begin
         chk($sformatf("%s tx[%0d]", nm, k), bus.TX_OUT, bits[k]);
         chk($sformatf("%s busy[%0d]", nm, k), bus.Busy, 1'b1);
         if (bus.Busy === 1'b1) busy_cnt++;
         if (disturb) begin
            bus.P_DATA     = (k == 3) ? '1 : DL'($urandom);
            bus.PAR_EN     = 1'($urandom);
            bus.PAR_TYP    = 1'($urandom);
            bus.DATA_VALID = (k == 3) ? 1'b1 : 1'($urandom);
         end
         @(negedge CLK);
      end
      bus.DATA_VALID = 1'b0;
      chk_int({nm, " busy_len"}, busy_cnt, exp_len);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s idle_tx[%0d]", nm, k), bus.TX_OUT, 1'b1);
         chk($sformatf("%s idle_busy[%0d]", nm, k), bus.Busy, 1'b0);
         @(negedge CLK);
      end
   endtask

   initial begin
      vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 10};
      vecs[1] = '{8'h55, 1'b1, 1'b0, 1'b0, 11};
      vecs[2] = '{8'h55, 1'b1, 1'b1, 1'b1, 11};
      vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1, 11};
      vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b0, 11};
      vecs[5] = '{8'hA3, 1'b0, 1'b1, 1'b0, 10};

      RST            = 1'b0;
      bus.P_DATA     = '0;
      bus.DATA_VALID = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;

      // Reset state, then quiet idle after release
      repeat (2) @(negedge CLK);
      chk("rst tx", bus.TX_OUT, 1'b1);
      chk("rst busy", bus.Busy, 1'b0);
      RST = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk($sformatf("post_rst tx[%0d]", k), bus.TX_OUT, 1'b1);
         chk($sformatf("post_rst busy[%0d]", k), bus.Busy, 1'b0);
      end

      // Directed table
      foreach (vecs[i])
         run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].pen, vecs[i].ptyp,
                   vecs[i].par, vecs[i].len, 1'b0);

      // Inputs changing and requests arriving mid-frame
      run_frame("midchg", 8'h55, 1'b0, 1'b0, 1'b0, 10, 1'b1);
      run_frame("midchg_par", 8'h07, 1'b1, 1'b1, 1'b0, 11, 1'b1);

      // Reset during data bit 3 of an all-zero frame
      bus.P_DATA     = 8'h00;
      bus.PAR_EN     = 1'b0;
      bus.DATA_VALID = 1'b1;
      @(negedge CLK);
      bus.DATA_VALID = 1'b0;
      repeat (4) @(negedge CLK);
      chk("pre_rst d3 tx", bus.TX_OUT, 1'b0);
      chk("pre_rst d3 busy", bus.Busy, 1'b1);
      #1 RST = 1'b0;
      #1;
      chk("async_rst tx", bus.TX_OUT, 1'b1);
      chk("async_rst busy", bus.Busy, 1'b0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("after_rst tx", bus.TX_OUT, 1'b1);
      chk("after_rst busy", bus.Busy, 1'b0);
      run_frame("after_rst_a3", 8'hA3, 1'b0, 1'b0, 1'b0, 10, 1'b0);

      // Random frames against the model
      for (int n = 0; n < 30; n++) begin
         logic [DL-1:0] d;
         logic          pen, ptyp, par;
         int            ones;
         d    = DL'($urandom);
         pen  = 1'($urandom);
         ptyp = 1'($urandom);
         ones = 0;
         for (int i = 0; i < DL; i++) ones += int'(d[i]);
         par  = ((ones % 2) == 1) ^ ptyp;
         run_frame($sformatf("rnd%0d", n), d, pen, ptyp, par,
                   DL + 2 + int'(pen), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
